// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: data-memory bus plus TX drain and input-latch signals of the responder
interface data_mem_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wr_en;
  logic [DATA_WIDTH-1:0] mem_data_wr;
  logic [DATA_WIDTH-1:0] mem_data_rd;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_strobe;
  modport slave (
    input  mem_addr, mem_wr_en, mem_data_wr, tx_ready, in_data, in_strobe,
    output mem_data_rd, tx_data, tx_valid
  );
  modport master (
    output mem_addr, mem_wr_en, mem_data_wr, tx_ready, in_data, in_strobe,
    input  mem_data_rd, tx_data, tx_valid
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: RAM-backed data bus with top-4 I/O (TX FIFO, status, input latch, timer)
// Define DMEM_TIMER_EN to turn the top address into a free-running loadable timer; otherwise it is RAM.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_AW    = 2
) (
  input logic clk,
  input logic arst,
  data_mem_responder_if.slave bus
);
  localparam int unsigned TOP = 2**ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] A_TX = ADDR_WIDTH'(TOP - 3);
  localparam logic [ADDR_WIDTH-1:0] A_ST = ADDR_WIDTH'(TOP - 2);
  localparam logic [ADDR_WIDTH-1:0] A_IN = ADDR_WIDTH'(TOP - 1);
  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] fifo [2**FIFO_AW];
  logic [FIFO_AW:0] rd_ptr, wr_ptr;
  logic tx_ovf, in_valid, in_ovr;
  logic [DATA_WIDTH-1:0] in_byte, timer, status, rd_next;
  logic tx_hit, st_hit, in_hit, tm_hit, empty, full, pop, push_req, push_ok, st_wr;
  assign tx_hit   = bus.mem_addr == A_TX;
  assign st_hit   = bus.mem_addr == A_ST;
  assign in_hit   = bus.mem_addr == A_IN;
  assign empty    = rd_ptr == wr_ptr;
  assign full     = (rd_ptr[FIFO_AW] != wr_ptr[FIFO_AW]) && (rd_ptr[FIFO_AW-1:0] == wr_ptr[FIFO_AW-1:0]);
  assign pop      = !empty && bus.tx_ready;
  assign push_req = bus.mem_wr_en && tx_hit;
  assign push_ok  = push_req && (!full || pop);
  assign st_wr    = bus.mem_wr_en && st_hit;
  assign status   = DATA_WIDTH'({in_ovr, in_valid, tx_ovf, full, empty});
  assign bus.tx_valid = !empty;
  assign bus.tx_data  = empty ? '0 : fifo[rd_ptr[FIFO_AW-1:0]];
`ifdef DMEM_TIMER_EN
  localparam logic [ADDR_WIDTH-1:0] A_TM = ADDR_WIDTH'(TOP);
  assign tm_hit = bus.mem_addr == A_TM;
  always_ff @(posedge clk)
    if (arst) timer <= '0;
    else timer <= (bus.mem_wr_en && tm_hit) ? bus.mem_data_wr : timer + 1'b1;
`else
  assign tm_hit = 1'b0;
  assign timer  = '0;
`endif
  always_comb
    rd_next = tx_hit ? '0 : st_hit ? status : in_hit ? in_byte : tm_hit ? timer : ram[bus.mem_addr];
  // Storage arrays carry no reset; only pointers and flags define visible state after reset.
  always_ff @(posedge clk) begin
    if (bus.mem_wr_en && !(tx_hit || st_hit || in_hit || tm_hit)) ram[bus.mem_addr] <= bus.mem_data_wr;
    if (push_ok) fifo[wr_ptr[FIFO_AW-1:0]] <= bus.mem_data_wr;
  end
  always_ff @(posedge clk)
    if (arst) begin
      bus.mem_data_rd <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tx_ovf   <= 1'b0;
      in_valid <= 1'b0;
      in_ovr   <= 1'b0;
      in_byte  <= '0;
    end else begin
      bus.mem_data_rd <= rd_next;
      rd_ptr   <= rd_ptr + (FIFO_AW+1)'(pop);
      wr_ptr   <= wr_ptr + (FIFO_AW+1)'(push_ok);
      tx_ovf   <= (push_req && full && !pop) || (tx_ovf && !(st_wr && bus.mem_data_wr[2]));
      in_valid <= bus.in_strobe || (in_valid && !(st_wr && bus.mem_data_wr[3]));
      in_ovr   <= (bus.in_strobe && in_valid) || (in_ovr && !(st_wr && bus.mem_data_wr[4]));
      in_byte  <= bus.in_strobe ? bus.in_data : in_byte;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed scoreboard bench for data_mem_responder (8-bit bus, depth-4 FIFO)
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;
  data_mem_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus();
  data_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .FIFO_AW(2)) dut (.clk(clk), .arst(arst), .bus(bus));
  int errs = 0;
  int checks = 0;
  logic [7:0] rq[$];
  logic [7:0] txq[$];
  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string tag);
    bus.mem_addr = a;
    bus.mem_wr_en = 1'b0;
    rq.push_back(e);
    tick();
    chk(tag, {1'b0, bus.mem_data_rd}, {1'b0, rq.pop_front()});
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.mem_addr = a;
    bus.mem_wr_en = 1'b1;
    bus.mem_data_wr = d;
    tick();
    bus.mem_wr_en = 1'b0;
  endtask
  task automatic push(input logic [7:0] d, input logic accepted);
    if (accepted) txq.push_back(d);
    wr(8'hFC, d);
  endtask
  task automatic strobe(input logic [7:0] d);
    bus.in_data = d;
    bus.in_strobe = 1'b1;
    tick();
    bus.in_strobe = 1'b0;
  endtask
  // Every handshake the DUT offers must deliver the oldest byte still owed.
  always @(negedge clk)
    if (!arst && bus.tx_valid && bus.tx_ready)
      chk("tx_data", {1'b1, bus.tx_data}, txq.size() > 0 ? {1'b1, txq.pop_front()} : 9'h000);
  initial begin
    #100000;
    $error("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
  initial begin
    bus.mem_addr = '0;
    bus.mem_wr_en = 1'b0;
    bus.mem_data_wr = '0;
    bus.tx_ready = 1'b0;
    bus.in_data = '0;
    bus.in_strobe = 1'b0;
    repeat (2) tick();
    arst = 1'b0;
    chk("rst_tx_valid", {8'h0, bus.tx_valid}, 9'h000);
    chk("rst_tx_data", {1'b0, bus.tx_data}, 9'h000);
    chk("rst_rd", {1'b0, bus.mem_data_rd}, 9'h000);
    rd(8'hFD, 8'h01, "rst_status");
    wr(8'h10, 8'hA5);
    rd(8'h10, 8'hA5, "ram_rd");
    bus.mem_addr = 8'h10;
    bus.mem_wr_en = 1'b1;
    bus.mem_data_wr = 8'h3C;
    rq.push_back(8'hA5);
    tick();
    bus.mem_wr_en = 1'b0;
    chk("ram_rbw", {1'b0, bus.mem_data_rd}, {1'b0, rq.pop_front()});
    rd(8'h10, 8'h3C, "ram_new");
    rd(8'hFC, 8'h00, "txdata_rd");
    for (int i = 1; i <= 4; i++) push(8'(i), 1'b1);
    rd(8'hFD, 8'h02, "fifo_full");
    push(8'h05, 1'b0);
    rd(8'hFD, 8'h06, "fifo_ovf");
    chk("tx_hold", {1'b0, bus.tx_data}, 9'h001);
    bus.tx_ready = 1'b1;
    repeat (4) tick();
    rd(8'hFD, 8'h05, "drained_status");
    chk("txq_left1", 9'(txq.size()), 9'd0);
    wr(8'hFD, 8'h04);
    rd(8'hFD, 8'h01, "ovf_clear");
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i), 1'b1);
    rd(8'hFD, 8'h02, "full2");
    bus.tx_ready = 1'b1;
    push(8'h77, 1'b1);
    repeat (4) tick();
    rd(8'hFD, 8'h01, "push_pop_full");
    chk("txq_left2", 9'(txq.size()), 9'd0);
    bus.tx_ready = 1'b0;
    strobe(8'h5A);
    rd(8'hFD, 8'h09, "in_valid");
    rd(8'hFE, 8'h5A, "in_rd1");
    rd(8'hFE, 8'h5A, "in_rd2");
    strobe(8'h11);
    rd(8'hFE, 8'h11, "in_over");
    rd(8'hFD, 8'h19, "in_ovr");
    wr(8'hFD, 8'h18);
    rd(8'hFD, 8'h01, "in_clear");
    bus.in_data = 8'h66;
    bus.in_strobe = 1'b1;
    wr(8'hFD, 8'h08);
    bus.in_strobe = 1'b0;
    rd(8'hFD, 8'h09, "strobe_wins");
    rd(8'hFE, 8'h66, "strobe_wins_data");
    wr(8'hFD, 8'h18);
`ifdef DMEM_TIMER_EN
    wr(8'hFF, 8'hFE);
    rd(8'hFF, 8'hFE, "timer0");
    rd(8'hFF, 8'hFF, "timer1");
    rd(8'hFF, 8'h00, "timer_wrap");
`else
    wr(8'hFF, 8'h42);
    rd(8'hFF, 8'h42, "top_ram1");
    rd(8'hFF, 8'h42, "top_ram2");
`endif
    for (int i = 0; i < 3; i++) push(8'hA1 + 8'(i), 1'b1);
    strobe(8'h33);
    rd(8'hFE, 8'h33, "pre_rst_in");
    arst = 1'b1;
    tick();
    arst = 1'b0;
    txq.delete();
    chk("mid_rst_tx_valid", {8'h0, bus.tx_valid}, 9'h000);
    chk("mid_rst_tx_data", {1'b0, bus.tx_data}, 9'h000);
    chk("mid_rst_rd", {1'b0, bus.mem_data_rd}, 9'h000);
    rd(8'hFD, 8'h01, "mid_rst_status");
    rd(8'hFE, 8'h00, "mid_rst_in");
    rd(8'h10, 8'h3C, "ram_kept");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
